// File: rtl/match_monitor_if.sv
// Bundles the recognizer-side inputs, the status/interrupt outputs and a debug
// view of the burst FSM state. The monitor connects through the slave modport.
interface match_monitor_if #(
    parameter int CNT_WIDTH = 8,
    parameter int GAP_WIDTH = 8,
    parameter int WIN_WIDTH = 8
);
    // No valid/ready pairs here: match_in is a one-cycle pulse per detection and
    // alarm_ack a one-cycle strobe; both are accepted unconditionally on the edge.
    logic                 match_in;
    logic                 clear;
    logic                 alarm_ack;
    logic [3:0]           threshold;
    logic [WIN_WIDTH-1:0] window;

    logic                 match_pulse;
    logic [CNT_WIDTH-1:0] match_count;
    logic                 overflow;
    logic [GAP_WIDTH-1:0] last_gap;
    logic                 gap_valid;
    logic                 burst_alarm;
    logic [1:0]           state_dbg;

    modport master (
        output match_in, clear, alarm_ack, threshold, window,
        input  match_pulse, match_count, overflow, last_gap, gap_valid,
               burst_alarm, state_dbg
    );

    modport slave (
        input  match_in, clear, alarm_ack, threshold, window,
        output match_pulse, match_count, overflow, last_gap, gap_valid,
               burst_alarm, state_dbg
    );
endinterface

// File: rtl/match_monitor.sv
// Match statistics and burst alarm stage behind the 1101 recognizer: registered
// match pulse, saturating count, inter-match gap and a windowed burst detector.
module match_monitor #(
    parameter int CNT_WIDTH = 8,
    parameter int GAP_WIDTH = 8,
    parameter int WIN_WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    match_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WINDOW = 2'd1,
        ALARM  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [GAP_WIDTH-1:0] GAP_MAX = '1;

    state_t               state_q, state_d;
    logic                 match_q, match_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [GAP_WIDTH-1:0] last_gap_q, last_gap_d;
    logic                 gap_valid_q, gap_valid_d;
    logic                 seen_q, seen_d;
    logic [WIN_WIDTH-1:0] timer_q, timer_d;
    logic [3:0]           bcnt_q, bcnt_d;

    logic [GAP_WIDTH-1:0] gap_inc;
    logic [4:0]           bcnt_inc;
    logic                 burst_hit;

    always_comb begin
        gap_inc   = (gap_cnt_q == GAP_MAX) ? gap_cnt_q : gap_cnt_q + GAP_WIDTH'(1);
        bcnt_inc  = {1'b0, bcnt_q} + 5'd1;
        burst_hit = (bcnt_inc >= {1'b0, bus.threshold});
    end

    // Statistics path; only the registered match is ever counted.
    always_comb begin
        match_d     = bus.match_in;
        count_d     = count_q;
        overflow_d  = overflow_q;
        gap_cnt_d   = gap_inc;
        last_gap_d  = last_gap_q;
        gap_valid_d = gap_valid_q;
        seen_d      = seen_q;

        if (match_q) begin
            gap_cnt_d = '0;
            seen_d    = 1'b1;
            if (count_q == CNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_WIDTH'(1);
            end
            // The first match after reset/clear only arms the gap measurement.
            if (seen_q) begin
                last_gap_d  = gap_inc;
                gap_valid_d = 1'b1;
            end
        end

        if (bus.clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            gap_cnt_d   = '0;
            last_gap_d  = '0;
            gap_valid_d = 1'b0;
            seen_d      = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bcnt_d  = bcnt_q;

        case (state_q)
            IDLE: begin
                if (match_q) begin
                    if (bus.threshold == 4'd1) begin
                        state_d = ALARM;
                    end else if (bus.threshold >= 4'd2) begin
                        state_d = WINDOW;
                        timer_d = bus.window;
                        bcnt_d  = 4'd1;
                    end
                end
            end
            WINDOW: begin
                if (match_q && burst_hit) begin
                    state_d = ALARM;
                end else if (match_q) begin
                    // A match landing exactly on expiry starts a fresh window.
                    if (timer_q == '0) begin
                        timer_d = bus.window;
                        bcnt_d  = 4'd1;
                    end else begin
                        timer_d = timer_q - WIN_WIDTH'(1);
                        bcnt_d  = bcnt_inc[3:0];
                    end
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - WIN_WIDTH'(1);
                end
            end
            ALARM: begin
                if (bus.alarm_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.clear) begin
            state_d = IDLE;
            timer_d = '0;
            bcnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            match_q     <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            gap_cnt_q   <= '0;
            last_gap_q  <= '0;
            gap_valid_q <= 1'b0;
            seen_q      <= 1'b0;
            timer_q     <= '0;
            bcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            gap_cnt_q   <= gap_cnt_d;
            last_gap_q  <= last_gap_d;
            gap_valid_q <= gap_valid_d;
            seen_q      <= seen_d;
            timer_q     <= timer_d;
            bcnt_q      <= bcnt_d;
        end
    end

    assign bus.match_pulse = match_q;
    assign bus.match_count = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.last_gap    = last_gap_q;
    assign bus.gap_valid   = gap_valid_q;
    assign bus.burst_alarm = (state_q == ALARM);
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_match_monitor.sv
// Bench for match_monitor: directed scenarios plus random traffic, every cycle
// compared against a timestamp-based reference model.
module tb_match_monitor;
    localparam int CW = 4;
    localparam int GW = 8;
    localparam int WW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int GAP_MAX = (1 << GW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    match_monitor_if #(.CNT_WIDTH(CW), .GAP_WIDTH(GW), .WIN_WIDTH(WW)) bus ();

    match_monitor #(.CNT_WIDTH(CW), .GAP_WIDTH(GW), .WIN_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    bit m_pulse, m_ovf, m_gap_valid, m_seen, m_alarm, m_active;
    int m_count, m_last_gap, m_last_t, m_expiry, m_bcnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    task automatic model_clear();
        m_count    = 0;
        m_ovf      = 0;
        m_last_gap = 0;
        m_gap_valid = 0;
        m_seen     = 0;
        m_alarm    = 0;
        m_active   = 0;
        m_bcnt     = 0;
    endtask

    // Burst tracking by timestamps: a window opened at edge s expires at s+window+1.
    task automatic model_step();
        bit mq;
        int thr;
        t++;
        if (rst) begin
            model_clear();
            m_pulse = 0;
            return;
        end
        mq      = m_pulse;
        m_pulse = bus.match_in;
        if (bus.clear) begin
            model_clear();
            return;
        end
        thr = int'(bus.threshold);
        if (mq) begin
            if (m_count == CNT_MAX) m_ovf = 1;
            else m_count++;
            if (m_seen) begin
                m_last_gap  = (t - m_last_t > GAP_MAX) ? GAP_MAX : t - m_last_t;
                m_gap_valid = 1;
            end
            m_seen   = 1;
            m_last_t = t;
        end
        if (m_alarm) begin
            if (bus.alarm_ack) m_alarm = 0;
        end else if (!m_active) begin
            if (mq && thr == 1) m_alarm = 1;
            else if (mq && thr >= 2) begin
                m_active = 1;
                m_bcnt   = 1;
                m_expiry = t + int'(bus.window) + 1;
            end
        end else if (mq && m_bcnt + 1 >= thr) begin
            m_alarm  = 1;
            m_active = 0;
        end else if (mq) begin
            if (t == m_expiry) begin
                m_bcnt   = 1;
                m_expiry = t + int'(bus.window) + 1;
            end else begin
                m_bcnt++;
            end
        end else if (t == m_expiry) begin
            m_active = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("match_pulse", 32'(bus.match_pulse), 32'(m_pulse));
        check_eq("match_count", 32'(bus.match_count), m_count);
        check_eq("overflow",    32'(bus.overflow),    32'(m_ovf));
        check_eq("last_gap",    32'(bus.last_gap),    m_last_gap);
        check_eq("gap_valid",   32'(bus.gap_valid),   32'(m_gap_valid));
        check_eq("burst_alarm", 32'(bus.burst_alarm), 32'(m_alarm));
    endtask

    task automatic drive(input bit mi, input int n);
        repeat (n) begin
            bus.match_in = mi;
            tick();
        end
        bus.match_in = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        drive(0, 1);
        bus.clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.match_in  = 1'b1;
        bus.clear     = 1'b0;
        bus.alarm_ack = 1'b0;
        bus.threshold = 4'd0;
        bus.window    = '0;
        model_clear();
        m_pulse = 0;

        // Reset with match_in held high, then a single pulse
        drive(1, 2);
        check_eq("rst_count", 32'(bus.match_count), 0);
        check_eq("rst_pulse", 32'(bus.match_pulse), 0);
        rst = 1'b0;
        drive(1, 1);
        drive(0, 1);
        check_eq("first_count", 32'(bus.match_count), 1);
        check_eq("first_gap_valid", 32'(bus.gap_valid), 0);

        // Gap of 3, then a saturated gap
        do_clear();
        drive(1, 1);
        drive(0, 2);
        drive(1, 1);
        drive(0, 1);
        check_eq("gap3", 32'(bus.last_gap), 3);
        check_eq("gap3_valid", 32'(bus.gap_valid), 1);
        drive(0, 299);
        drive(1, 1);
        drive(0, 1);
        check_eq("gap_sat", 32'(bus.last_gap), 255);

        // Count saturation and clear
        do_clear();
        drive(1, 16);
        drive(0, 2);
        check_eq("cnt_sat", 32'(bus.match_count), 15);
        check_eq("ovf_set", 32'(bus.overflow), 1);
        do_clear();
        check_eq("clr_count", 32'(bus.match_count), 0);
        check_eq("clr_ovf", 32'(bus.overflow), 0);
        check_eq("clr_gap", 32'(bus.last_gap), 0);

        // Burst hit: pulses 0,4,8 with threshold 3, window 10; ack at 20
        bus.threshold = 4'd3;
        bus.window    = 8'd10;
        drive(1, 1); drive(0, 3);
        drive(1, 1); drive(0, 3);
        drive(1, 1);
        check_eq("hit_pre", 32'(bus.burst_alarm), 0);
        drive(0, 1);
        check_eq("hit_alarm", 32'(bus.burst_alarm), 1);
        drive(0, 2); drive(1, 1); drive(0, 2); drive(1, 1); drive(0, 3);
        drive(1, 1);
        check_eq("hit_hold", 32'(bus.burst_alarm), 1);
        bus.alarm_ack = 1'b1;
        drive(0, 1);
        bus.alarm_ack = 1'b0;
        check_eq("ack_fall", 32'(bus.burst_alarm), 0);
        check_eq("ack_cycle_count", 32'(bus.match_count), 6);
        check_eq("ack_idle", 32'(bus.state_dbg), 0);
        drive(0, 2);
        check_eq("ack_no_rearm", 32'(bus.burst_alarm), 0);

        // Burst miss then restart: threshold 3, window 5
        do_clear();
        bus.window = 8'd5;
        drive(1, 1); drive(0, 2); drive(1, 1); drive(0, 16);
        check_eq("miss_no_alarm", 32'(bus.burst_alarm), 0);
        drive(1, 1); drive(0, 2); drive(1, 1); drive(0, 2); drive(1, 1);
        check_eq("restart_pre", 32'(bus.burst_alarm), 0);
        drive(0, 1);
        check_eq("restart_alarm", 32'(bus.burst_alarm), 1);
        bus.alarm_ack = 1'b1;
        drive(0, 1);
        bus.alarm_ack = 1'b0;

        // threshold 0 never alarms
        bus.threshold = 4'd0;
        for (int i = 0; i < 60; i++) drive(1'($urandom_range(0, 1)), 1);
        drive(0, 2);
        check_eq("thr0_quiet", 32'(bus.burst_alarm), 0);

        // threshold 1 alarms two cycles after the pulse
        bus.threshold = 4'd1;
        drive(1, 1);
        check_eq("thr1_pre", 32'(bus.burst_alarm), 0);
        drive(0, 1);
        check_eq("thr1_alarm", 32'(bus.burst_alarm), 1);
        bus.alarm_ack = 1'b1;
        drive(0, 1);
        bus.alarm_ack = 1'b0;

        // Reset while a window is open
        bus.threshold = 4'd3;
        bus.window    = 8'd20;
        drive(1, 1); drive(0, 3);
        check_eq("win_state", 32'(bus.state_dbg), 1);
        rst = 1'b1;
        drive(0, 1);
        rst = 1'b0;
        check_eq("rst_win_state", 32'(bus.state_dbg), 0);
        check_eq("rst_win_count", 32'(bus.match_count), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                bus.threshold = 4'($urandom_range(0, 5));
                bus.window    = 8'($urandom_range(0, 15));
            end
            rst           = ($urandom_range(0, 499) == 0);
            bus.clear     = ($urandom_range(0, 299) == 0);
            bus.alarm_ack = ($urandom_range(0, 7) == 0);
            bus.match_in  = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0;
        bus.clear = 1'b0;
        bus.alarm_ack = 1'b0;
        drive(0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
